// File: rtl/sat_pkg.sv
// Shared encodings for the clause array: base-cell value codes and the
// clause status state machine encoding.
package sat_pkg;

  localparam logic [1:0] VAL_FREE = 2'b00;
  localparam logic [1:0] VAL_CONF = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPEN     = 3'd1,
    ST_UNIT     = 3'd2,
    ST_SAT      = 3'd3,
    ST_CONFLICT = 3'd4
  } clause_state_t;

  // Saturating increment of the 2-bit free count: 00 -> 01 -> 11 -> 11.
  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    return (cnt == 2'b00) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/clause_lit_slot.sv
// One literal slot of a clause cell: stored literal, implied flag and the
// decision level at which this cell implied the slot's variable.
module clause_lit_slot
  import sat_pkg::*;
#(
  parameter int LVL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [1:0]       lit_wr,
  input  logic             bkt,
  input  logic [LVL_W-1:0] bkt_lvl,
  input  logic [LVL_W-1:0] cur_lvl,
  input  logic [1:0]       val,
  input  logic             imp_act,
  input  logic             cc_act,
  output logic [1:0]       lit,
  output logic             part,
  output logic             free,
  output logic             sat,
  output logic             conf_own,
  output logic [2:0]       drv
);

  logic [1:0]       lit_q;
  logic             imp_q;
  logic [LVL_W-1:0] lvl_q;
  logic             cap;
  logic             imp_keep;

  assign lit  = lit_q;
  assign part = (lit_q != 2'b00);
  assign free = (val == VAL_FREE);
  assign sat  = part && (val == lit_q);

  // imp_act is only raised when the clause has exactly one free slot, so at
  // most one slot captures in any cycle.
  assign cap = imp_act && part && free;

  // The flag as it will stand after this cycle's backtrack, so a backtrack
  // cycle re-evaluates the clause with the undone implication already gone.
  assign imp_keep = imp_q && !(bkt && (lvl_q > bkt_lvl));
  assign conf_own = imp_keep && part && ((val == VAL_CONF) || (val == ~lit_q));

  // Implication wins over conflict marking; non-participating slots stay quiet.
  always_comb begin
    drv = 3'b000;
    if (cap)
      drv = {lit_q, 1'b1};
    else if (cc_act && part)
      drv = {VAL_CONF, 1'b0};
  end

  // Literal store, implied flag and level: load > backtrack > capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lit_q <= 2'b00;
      imp_q <= 1'b0;
      lvl_q <= '0;
    end else if (wr) begin
      lit_q <= lit_wr;
      imp_q <= 1'b0;
      lvl_q <= '0;
    end else if (bkt) begin
      if (imp_q && (lvl_q > bkt_lvl))
        imp_q <= 1'b0;
    end else if (cap) begin
      imp_q <= 1'b1;
      lvl_q <= cur_lvl;
    end
  end

endmodule

// File: rtl/clause_cell_n.sv
// Clause cell: NUM_LIT literal slots, free-literal count, registered
// SAT/UNIT/CONFLICT status and implication / conflict-mark drive.
// Build option CLAUSE_CONFLICT_LATCH_EN: when defined, CONFLICT holds until
// a literal load or a backtrack; otherwise it is re-evaluated every cycle.
module clause_cell_n
  import sat_pkg::*;
#(
  parameter int NUM_LIT = 8,
  parameter int LVL_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*NUM_LIT-1:0] var_value_i,
  output logic [3*NUM_LIT-1:0] var_value_o,
  input  logic                 wr_i,
  input  logic [2*NUM_LIT-1:0] lit_i,
  output logic [2*NUM_LIT-1:0] lit_o,
  input  logic [LVL_W-1:0]     cur_lvl_i,
  input  logic                 bkt_i,
  input  logic [LVL_W-1:0]     bkt_lvl_i,
  input  logic                 imp_drv_i,
  input  logic                 cclause_drv_i,
  output logic [1:0]           freelitcnt_o,
  output logic                 clausesat_o,
  output logic                 unit_o,
  output logic                 cclause_o
);

  clause_state_t state_q;
  clause_state_t state_nxt;
  clause_state_t state_eval;

  logic [NUM_LIT-1:0] part;
  logic [NUM_LIT-1:0] free;
  logic [NUM_LIT-1:0] sat;
  logic [NUM_LIT-1:0] conf_own;
  logic [NUM_LIT-1:0] imp_in;
  logic               imp_act;
  logic               cc_act;
  logic               unused_imp_in;

  // The incoming imp bits belong to other clauses' bookkeeping, not ours.
  assign unused_imp_in = ^imp_in;

  // Load and backtrack cycles suppress the drive so nothing is left
  // implied without a matching flag.
  assign imp_act = (state_q == ST_UNIT) && imp_drv_i && (freelitcnt_o == 2'b01)
                   && !wr_i && !bkt_i;
  assign cc_act  = cclause_drv_i && !imp_act;

  for (genvar i = 0; i < NUM_LIT; i++) begin : g_slot
    assign imp_in[i] = var_value_i[3*i];

    clause_lit_slot #(.LVL_W(LVL_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_i),
      .lit_wr   (lit_i[2*i +: 2]),
      .bkt      (bkt_i),
      .bkt_lvl  (bkt_lvl_i),
      .cur_lvl  (cur_lvl_i),
      .val      (var_value_i[3*i+1 +: 2]),
      .imp_act  (imp_act),
      .cc_act   (cc_act),
      .lit      (lit_o[2*i +: 2]),
      .part     (part[i]),
      .free     (free[i]),
      .sat      (sat[i]),
      .conf_own (conf_own[i]),
      .drv      (var_value_o[3*i +: 3])
    );
  end

  // Saturating count of participating free slots.
  always_comb begin
    freelitcnt_o = 2'b00;
    for (int i = 0; i < NUM_LIT; i++)
      if (part[i] && free[i])
        freelitcnt_o = sat_inc(freelitcnt_o);
  end

  // Clause status from the current slot values, then load/latch overrides.
  always_comb begin
    state_eval = ST_OPEN;
    if (part == '0)
      state_eval = ST_IDLE;
    else if (sat != '0)
      state_eval = ST_SAT;
    else if ((freelitcnt_o == 2'b00) && (conf_own != '0))
      state_eval = ST_CONFLICT;
    else if (freelitcnt_o == 2'b01)
      state_eval = ST_UNIT;

    state_nxt = state_eval;
    if (wr_i)
      state_nxt = ST_IDLE;
`ifdef CLAUSE_CONFLICT_LATCH_EN
    else if ((state_q == ST_CONFLICT) && !bkt_i)
      state_nxt = ST_CONFLICT;
`endif
  end

  // State register with registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      clausesat_o <= 1'b0;
      unit_o      <= 1'b0;
      cclause_o   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      clausesat_o <= (state_nxt == ST_SAT);
      unit_o      <= (state_nxt == ST_UNIT);
      cclause_o   <= (state_nxt == ST_CONFLICT);
    end
  end

endmodule

// File: tb/tb_clause_cell_n.sv
// Directed bench for clause_cell_n with NUM_LIT=4; handles both builds of
// CLAUSE_CONFLICT_LATCH_EN.
module tb_clause_cell_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] var_value_i;
  logic [11:0] var_value_o;
  logic        wr_i;
  logic [7:0]  lit_i;
  logic [7:0]  lit_o;
  logic [7:0]  cur_lvl_i;
  logic        bkt_i;
  logic [7:0]  bkt_lvl_i;
  logic        imp_drv_i;
  logic        cclause_drv_i;
  logic [1:0]  freelitcnt_o;
  logic        clausesat_o;
  logic        unit_o;
  logic        cclause_o;

  int n_chk  = 0;
  int n_pass = 0;

  clause_cell_n #(.NUM_LIT(4), .LVL_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .var_value_i   (var_value_i),
    .var_value_o   (var_value_o),
    .wr_i          (wr_i),
    .lit_i         (lit_i),
    .lit_o         (lit_o),
    .cur_lvl_i     (cur_lvl_i),
    .bkt_i         (bkt_i),
    .bkt_lvl_i     (bkt_lvl_i),
    .imp_drv_i     (imp_drv_i),
    .cclause_drv_i (cclause_drv_i),
    .freelitcnt_o  (freelitcnt_o),
    .clausesat_o   (clausesat_o),
    .unit_o        (unit_o),
    .cclause_o     (cclause_o)
  );

  always #5 clk = ~clk;

  // Slot values, slot 0 first; incoming imp bits held at 0.
  function automatic logic [11:0] vv(input logic [1:0] s0, input logic [1:0] s1,
                                     input logic [1:0] s2, input logic [1:0] s3);
    return {s3, 1'b0, s2, 1'b0, s1, 1'b0, s0, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; wr_i = 1'b0; lit_i = 8'h00; var_value_i = 12'h000;
    cur_lvl_i = 8'd0; bkt_i = 1'b0; bkt_lvl_i = 8'd0;
    imp_drv_i = 1'b0; cclause_drv_i = 1'b0;
    #12;
    chk("rst_lit", lit_o, 8'h00);
    chk("rst_cnt", freelitcnt_o, 2'b00);
    chk("rst_stat", {clausesat_o, unit_o, cclause_o}, 3'b000);
    chk("rst_drv", var_value_o, 12'h000);
    step();
    rst = 1'b1;
    step();

    // Load literals slot0..3 = 01,10,00,01.
    wr_i = 1'b1; lit_i = 8'b01_00_10_01;
    step();
    wr_i = 1'b0;
    chk("load_lit", lit_o, 8'b01_00_10_01);
    chk("load_cnt", freelitcnt_o, 2'b11);
    chk("load_idle", {clausesat_o, unit_o, cclause_o}, 3'b000);
    step();
    chk("open_stat", {clausesat_o, unit_o, cclause_o}, 3'b000);

    // Slots 0,1 assigned against their literals -> one free -> UNIT.
    var_value_i = vv(2'b10, 2'b01, 2'b00, 2'b00);
    #1 chk("unit_cnt", freelitcnt_o, 2'b01);
    step();
    chk("unit_stat", {clausesat_o, unit_o, cclause_o}, 3'b010);

    // Implication at level 3 with conflict marking also requested: imp wins.
    imp_drv_i = 1'b1; cclause_drv_i = 1'b1; cur_lvl_i = 8'd3;
    #1 chk("imp_drv", var_value_o, 12'b011_000_000_000);
    step();
    imp_drv_i = 1'b0; cclause_drv_i = 1'b0;
    chk("unit_hold", unit_o, 1'b1);

    // Base cell marks slot 3 conflicting -> CONFLICT.
    var_value_i = vv(2'b10, 2'b01, 2'b00, 2'b11);
    step();
    chk("conf_set", {unit_o, cclause_o}, 2'b01);
    cclause_drv_i = 1'b1;
    #1 chk("cc_drv", var_value_o, 12'b110_000_110_110);
    cclause_drv_i = 1'b0;

    // Slot 3 value released: transient build goes UNIT, latched build holds.
    var_value_i = vv(2'b10, 2'b01, 2'b00, 2'b00);
    step();
`ifdef CLAUSE_CONFLICT_LATCH_EN
    chk("conf_latch", {unit_o, cclause_o}, 2'b01);
`else
    chk("conf_trans", {unit_o, cclause_o}, 2'b10);
`endif
    var_value_i = vv(2'b10, 2'b01, 2'b00, 2'b11);
    step();
    chk("conf_again", cclause_o, 1'b1);

    // Backtrack to the implication level keeps the flag.
    bkt_i = 1'b1; bkt_lvl_i = 8'd3;
    step();
    chk("bkt_keep", cclause_o, 1'b1);
    // Backtrack below it clears the flag and leaves CONFLICT.
    bkt_lvl_i = 8'd2;
    step();
    bkt_i = 1'b0;
    chk("bkt_clr", cclause_o, 1'b0);
    step();
    chk("bkt_stays", {clausesat_o, unit_o, cclause_o}, 3'b000);

    // Satisfaction: slot 1 takes its literal value 10.
    var_value_i = vv(2'b00, 2'b01, 2'b00, 2'b00);
    step();
    chk("pre_sat_cnt", freelitcnt_o, 2'b11);
    var_value_i = vv(2'b00, 2'b10, 2'b00, 2'b00);
    #1 chk("sat_cnt", freelitcnt_o, 2'b11);
    chk("sat_lat", clausesat_o, 1'b0);
    step();
    chk("sat_stat", {clausesat_o, unit_o, cclause_o}, 3'b100);

    // Back to UNIT, then load with backtrack and implication in the same cycle.
    var_value_i = vv(2'b10, 2'b01, 2'b00, 2'b00);
    step();
    chk("unit2", unit_o, 1'b1);
    wr_i = 1'b1; bkt_i = 1'b1; bkt_lvl_i = 8'd0; imp_drv_i = 1'b1; cur_lvl_i = 8'd5;
    lit_i = 8'b00_01_10_10;
    #1 chk("wr_nodrv", var_value_o, 12'h000);
    step();
    wr_i = 1'b0; bkt_i = 1'b0; imp_drv_i = 1'b0;
    chk("wr_lit", lit_o, 8'b00_01_10_10);
    chk("wr_idle", {clausesat_o, unit_o, cclause_o}, 3'b000);
    var_value_i = vv(2'b00, 2'b00, 2'b00, 2'b00);
    step();
    chk("wr_cnt", freelitcnt_o, 2'b11);
    // All participating slots falsified with no owned implication -> OPEN.
    var_value_i = vv(2'b01, 2'b01, 2'b10, 2'b00);
    step();
    chk("noflag_open", {clausesat_o, unit_o, cclause_o}, 3'b000);

    // UNIT on slot 2, drive, then asynchronous reset mid-drive.
    var_value_i = vv(2'b01, 2'b01, 2'b00, 2'b00);
    step();
    chk("unit3", unit_o, 1'b1);
    imp_drv_i = 1'b1; cur_lvl_i = 8'd1;
    #1 chk("imp_drv2", var_value_o, 12'b000_011_000_000);
    #1 rst = 1'b0;
    #1 chk("arst_drv", var_value_o, 12'h000);
    chk("arst_stat", {clausesat_o, unit_o, cclause_o}, 3'b000);
    chk("arst_lit", lit_o, 8'h00);
    chk("arst_cnt", freelitcnt_o, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
